dtmf_keypad_scanner: RTL and testbench

Scans a 4x4 DTMF telephone keypad matrix and reports debounced key presses. It is paced by the 60 Hz square wave produced by the upstream stepdown divider. It runs entirely in the 1 MHz domain and treats the 60 Hz input as an asynchronous pacing signal. Each accepted key produces a 4-bit {row, col} code for the downstream DTMF tone generator: row selects the low-group tone, col selects the high-group tone.

---
 rtl/dtmf_pkg.sv | 38 +++
 rtl/dtmf_sync_edge.sv | 44 ++++
 rtl/dtmf_keypad_scanner.sv | 127 ++++++++++++
 tb/tb_dtmf_keypad_scanner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dtmf_pkg.sv
// Shared types and constants for the DTMF keypad scanner.
package dtmf_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Key codes are {row, col}; row picks the low-group tone, col the high-group tone.
  localparam logic [3:0] KEY_1    = 4'h0;
  localparam logic [3:0] KEY_2    = 4'h1;
  localparam logic [3:0] KEY_3    = 4'h2;
  localparam logic [3:0] KEY_A    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_B    = 4'h7;
  localparam logic [3:0] KEY_7    = 4'h8;
  localparam logic [3:0] KEY_8    = 4'h9;
  localparam logic [3:0] KEY_9    = 4'hA;
  localparam logic [3:0] KEY_C    = 4'hB;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_0    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_D    = 4'hF;

  // Index of the lowest active-low row; 0 when no row is low.
  function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] rows);
    low_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--)
      if (!rows[i]) low_row = 2'(i);
  endfunction

endpackage

// File: rtl/dtmf_sync_edge.sv
// Two-flop synchronizer; with EDGE set, the output is instead a registered
// one-cycle pulse on each rising edge of the synchronized input.
module dtmf_sync_edge #(
  parameter int            W       = 1,
  parameter bit            EDGE    = 1'b0,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_1m_in,
  input  logic         reset_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1, s2;

  always_ff @(posedge clk_1m_in or negedge reset_b) begin
    if (!reset_b) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic [W-1:0] s3, rise;
      always_ff @(posedge clk_1m_in or negedge reset_b) begin
        if (!reset_b) begin
          s3   <= RST_VAL;
          rise <= '0;
        end else begin
          s3   <= s2;
          rise <= s2 & ~s3;
        end
      end
      assign q = rise;
    end else begin : g_sync
      assign q = s2;
    end
  endgenerate

endmodule

// File: rtl/dtmf_keypad_scanner.sv
// 4x4 keypad scanner: column walk, press/release debounce, {row,col} key code.
module dtmf_keypad_scanner
  import dtmf_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic       clk_1m_in,
  input  logic       reset_b,
  input  logic       scan_clk_in,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // Counters are compared against TERM before incrementing, so they never wrap.
  localparam logic [3:0] TERM = 4'(DEBOUNCE_TICKS - 1);

  logic       scan_tick;
  logic [3:0] rows_s;

  dtmf_sync_edge #(.W(1), .EDGE(1'b1), .RST_VAL(1'b0)) u_scan_sync (
    .clk_1m_in (clk_1m_in),
    .reset_b   (reset_b),
    .d         (scan_clk_in),
    .q         (scan_tick)
  );

  dtmf_sync_edge #(.W(4), .EDGE(1'b0), .RST_VAL(4'hF)) u_row_sync (
    .clk_1m_in (clk_1m_in),
    .reset_b   (reset_b),
    .d         (row_in),
    .q         (rows_s)
  );

  state_t     state, state_n;
  logic [1:0] col, col_n, row, row_n;
  logic [3:0] cnt, cnt_n, rel_cnt, rel_cnt_n, key_code_n;
  logic       key_valid_n, key_held_n;
  logic       lower_low;

  assign col_out   = ~(4'b0001 << col);
  assign lower_low = |(~rows_s & ((4'b0001 << row) - 4'b0001));

  always_ff @(posedge clk_1m_in or negedge reset_b) begin
    if (!reset_b) begin
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      cnt       <= 4'd0;
      rel_cnt   <= 4'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      cnt       <= cnt_n;
      rel_cnt   <= rel_cnt_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
    end
  end

  always_comb begin
    state_n     = state;
    col_n       = col;
    row_n       = row;
    cnt_n       = cnt;
    rel_cnt_n   = rel_cnt;
    key_code_n  = key_code;
    key_valid_n = 1'b0;
    key_held_n  = key_held;
    if (scan_tick) begin
      case (state)
        SCAN: begin
          if (rows_s == 4'hF) begin
            col_n = col + 2'd1;
          end else begin
            row_n = low_row(rows_s);
            if (DEBOUNCE_TICKS == 1) begin
              key_code_n  = {low_row(rows_s), col};
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              cnt_n       = 4'd0;
              state_n     = HELD;
            end else begin
              cnt_n   = 4'd1;
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          // A lower-index row taking over counts as a new press, so restart.
          if (rows_s[row] || lower_low) begin
            cnt_n   = 4'd0;
            state_n = SCAN;
          end else if (cnt == TERM) begin
            key_code_n  = {row, col};
            key_valid_n = 1'b1;
            key_held_n  = 1'b1;
            cnt_n       = 4'd0;
            state_n     = HELD;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        HELD: begin
          if (!rows_s[row]) begin
            rel_cnt_n = 4'd0;
          end else if (rel_cnt == TERM) begin
            rel_cnt_n  = 4'd0;
            key_held_n = 1'b0;
            state_n    = SCAN;
          end else begin
            rel_cnt_n = rel_cnt + 4'd1;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_dtmf_keypad_scanner.sv
// Tick-level reference model of the scanner driven by directed and random keypad activity.
module tb_dtmf_keypad_scanner;

  localparam int DT = 3;
  localparam int P_SCAN = 0, P_DEB = 1, P_HELD = 2;

  logic       clk_1m_in = 1'b0;
  logic       reset_b = 1'b0;
  logic       scan_clk_in = 1'b0;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out, key_code;
  logic       key_valid, key_held;

  dtmf_keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
    .clk_1m_in   (clk_1m_in),
    .reset_b     (reset_b),
    .scan_clk_in (scan_clk_in),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

  always #5 clk_1m_in = ~clk_1m_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one call per scan tick, given the row pattern seen on that tick.
  int   m_ph, m_col, m_row, m_cnt, m_rel;
  int   m_code;
  logic m_held, e_valid;

  task automatic model_reset();
    m_ph = P_SCAN; m_col = 0; m_row = 0; m_cnt = 0; m_rel = 0;
    m_code = 0; m_held = 1'b0; e_valid = 1'b0;
  endtask

  task automatic model_accept();
    m_code  = m_row * 4 + m_col;
    e_valid = 1'b1;
    m_held  = 1'b1;
    m_ph    = P_HELD;
    m_cnt   = 0;
  endtask

  task automatic model_tick(input logic [3:0] r);
    int low;
    low = -1;
    for (int i = 3; i >= 0; i--) if (!r[i]) low = i;
    e_valid = 1'b0;
    case (m_ph)
      P_SCAN:
        if (low < 0) m_col = (m_col + 1) % 4;
        else begin
          m_row = low;
          if (DT == 1) model_accept();
          else begin m_cnt = 1; m_ph = P_DEB; end
        end
      P_DEB:
        // The press survives only while its row is still the lowest low row.
        if (low != m_row) begin m_cnt = 0; m_ph = P_SCAN; end
        else if (m_cnt + 1 == DT) model_accept();
        else m_cnt++;
      default:
        if (r[m_row]) begin
          if (m_rel + 1 == DT) begin m_rel = 0; m_held = 1'b0; m_ph = P_SCAN; end
          else m_rel++;
        end else m_rel = 0;
    endcase
  endtask

  function automatic logic [3:0] exp_col();
    return 4'hF ^ (4'd1 << m_col);
  endfunction

  task automatic check_outputs(input string pfx);
    chk({pfx, "col_out"},   32'(col_out),   32'(exp_col()));
    chk({pfx, "key_valid"}, 32'(key_valid), 32'(e_valid));
    chk({pfx, "key_held"},  32'(key_held),  32'(m_held));
    chk({pfx, "key_code"},  32'(key_code),  32'(m_code));
  endtask

  task automatic do_tick(input logic [3:0] r);
    row_in = r;
    repeat (3) @(negedge clk_1m_in);
    scan_clk_in = 1'b1;
    model_tick(r);
    repeat (4) @(negedge clk_1m_in);
    check_outputs("tick_");
    @(negedge clk_1m_in);
    chk("valid_pulse_width", 32'(key_valid), 32'd0);
    scan_clk_in = 1'b0;
    // Row activity between ticks must not matter.
    row_in = 4'($urandom);
    repeat (2) @(negedge clk_1m_in);
  endtask

  task automatic goto_col(input int c);
    for (int i = 0; i < 4 && m_col != c; i++) do_tick(4'hF);
  endtask

  function automatic logic [3:0] keypad(input logic [15:0] pk);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) if (pk[i * 4 + m_col]) r[i] = 1'b0;
    return r;
  endfunction

  initial begin
    logic [15:0] pk;
    model_reset();
    repeat (3) @(negedge clk_1m_in);
    chk("rst_col_out", 32'(col_out), 32'hE);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_key_held", 32'(key_held), 32'h0);
    reset_b = 1'b1;
    repeat (3) @(negedge clk_1m_in);

    // Free scan through all four columns.
    for (int i = 0; i < 4; i++) do_tick(4'hF);
    chk("free_scan_wrap", 32'(col_out), 32'hE);

    // Press '5' (row 1, col 1), then release.
    goto_col(1);
    for (int i = 0; i < 3; i++) do_tick(4'b1101);
    chk("press5_code", 32'(key_code), 32'h5);
    chk("press5_col_frozen", 32'(col_out), 32'hD);
    for (int i = 0; i < 3; i++) do_tick(4'hF);

    // One-tick bounce, then idle: column resumes.
    do_tick(4'b1011);
    do_tick(4'hF);
    do_tick(4'hF);

    // '#' (row 3, col 2) with a bouncy release.
    goto_col(2);
    for (int i = 0; i < 3; i++) do_tick(4'b0111);
    chk("hash_code", 32'(key_code), 32'hE);
    do_tick(4'hF); do_tick(4'hF); do_tick(4'b0111);
    do_tick(4'hF); do_tick(4'hF);
    chk("hash_still_held", 32'(key_held), 32'd1);
    do_tick(4'hF);
    chk("hash_released", 32'(key_held), 32'd0);

    // Rows 0 and 2 low in col 3 -> key 'A'.
    goto_col(3);
    for (int i = 0; i < 3; i++) do_tick(4'b1010);
    chk("multi_row_code", 32'(key_code), 32'h3);
    for (int i = 0; i < 3; i++) do_tick(4'hF);

    // Asynchronous reset in the middle of a debounce.
    goto_col(1);
    do_tick(4'b1101);
    do_tick(4'b1101);
    #2 reset_b = 1'b0;
    #1;
    model_reset();
    chk("midrst_col_out", 32'(col_out), 32'hE);
    chk("midrst_key_valid", 32'(key_valid), 32'h0);
    chk("midrst_key_held", 32'(key_held), 32'h0);
    chk("midrst_key_code", 32'(key_code), 32'h0);
    @(negedge clk_1m_in);
    reset_b = 1'b1;
    do_tick(4'hF);
    do_tick(4'hF);

    // Stuck scan clock: nothing may move.
    for (int i = 0; i < 40; i++) begin
      row_in = 4'($urandom);
      @(negedge clk_1m_in);
    end
    check_outputs("stuck_");

    // Random keypad activity with bounce.
    pk = 16'h0;
    for (int t = 0; t < 300; t++) begin
      logic [3:0] r;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: pk = 16'h0;
          2: pk = 16'(1) << $urandom_range(0, 15);
          default: pk = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      r = keypad(pk);
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      do_tick(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
